// File: rtl/rggb_unpacker.sv
// rggb_unpacker: serialises packed {R,G1,G2,B} words into a tagged byte stream via a 2-entry buffer.
// Optional RGGB_UNPACKER_LINE_CNT_EN adds line_count and line_start outputs.
module rggb_unpacker #(
    parameter int LINE_WORDS = 640
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    output logic [7:0]  byte_out,
    output logic [1:0]  byte_chan,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        byte_last
`ifdef RGGB_UNPACKER_LINE_CNT_EN
  , output logic [15:0] line_count
  , output logic        line_start
`endif
);
    logic [31:0] mem [2];
    logic        head, tail;
    logic [1:0]  count, chan_idx;
    logic [15:0] word_cnt;
    logic        push, acc, pop, at_end;
    always_comb begin
        word_ready = count != 2'd2;
        byte_valid = count != 2'd0;
        push       = word_valid & word_ready;
        acc        = byte_valid & byte_ready;
        pop        = acc & (chan_idx == 2'd3);
        at_end     = word_cnt == 16'(LINE_WORDS - 1);
        // ~chan_idx maps R..B onto slice offsets 24,16,8,0
        byte_out   = byte_valid ? mem[head][{~chan_idx, 3'b000} +: 8] : 8'd0;
        byte_chan  = byte_valid ? chan_idx : 2'd0;
        byte_last  = byte_valid & (chan_idx == 2'd3) & at_end;
    end
    always_ff @(posedge clk) begin
        if (push)
            mem[tail] <= word_in;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= 1'b0;
            tail     <= 1'b0;
            count    <= 2'd0;
            chan_idx <= 2'd0;
            word_cnt <= 16'd0;
        end else begin
            if (push)
                tail <= ~tail;
            if (acc)
                chan_idx <= chan_idx + 2'd1;
            if (pop) begin
                head     <= ~head;
                word_cnt <= at_end ? 16'd0 : word_cnt + 16'd1;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end
`ifdef RGGB_UNPACKER_LINE_CNT_EN
    assign line_start = byte_valid & (chan_idx == 2'd0) & (word_cnt == 16'd0);
    always_ff @(posedge clk) begin
        if (rst)
            line_count <= 16'd0;
        else if (acc & byte_last)
            line_count <= line_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_rggb_unpacker.sv
// tb_rggb_unpacker: directed vector table plus randomized scoreboard run for rggb_unpacker.
module tb_rggb_unpacker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] word_in = '0;
    logic        word_valid = 1'b0;
    logic        byte_ready = 1'b0;
    logic        word_ready, byte_valid, byte_last;
    logic [7:0]  byte_out;
    logic [1:0]  byte_chan;
    logic        word_ready3, byte_valid3, byte_last3;
    logic [7:0]  byte_out3;
    logic [1:0]  byte_chan3;
`ifdef RGGB_UNPACKER_LINE_CNT_EN
    logic [15:0] line_count, line_count3;
    logic        line_start, line_start3;
`endif

    always #5 clk = ~clk;

    rggb_unpacker #(.LINE_WORDS(2)) u2 (
        .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready), .byte_out(byte_out), .byte_chan(byte_chan),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_last(byte_last)
`ifdef RGGB_UNPACKER_LINE_CNT_EN
      , .line_count(line_count), .line_start(line_start)
`endif
    );

    rggb_unpacker #(.LINE_WORDS(3)) u3 (
        .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready3), .byte_out(byte_out3), .byte_chan(byte_chan3),
        .byte_valid(byte_valid3), .byte_ready(byte_ready), .byte_last(byte_last3)
`ifdef RGGB_UNPACKER_LINE_CNT_EN
      , .line_count(line_count3), .line_start(line_start3)
`endif
    );

    typedef struct {
        logic        r;
        logic        wv;
        logic [31:0] wd;
        logic        br;
        logic        wr;
        logic        bv;
        logic [7:0]  b;
        logic [1:0]  ch;
        logic        l;
    } vec_t;

    typedef struct {
        logic [7:0] b;
        logic [1:0] ch;
    } exp_t;

    vec_t tab[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_fail = 0;
    int   nb = 0;
    int   lasts3 = 0;
    logic [15:0] lc2 = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, then score the handshakes the next edge will see.
    task automatic step(input logic r, input logic wv, input logic [31:0] wd, input logic br,
                        output logic acc);
        exp_t e;
        logic l2, l3;
        @(negedge clk);
        rst = r; word_valid = wv; word_in = wd; byte_ready = br;
        #1;
        acc = !r && wv && word_ready;
        if (r) begin
            sb.delete();
            nb = 0;
            lc2 = '0;
        end else begin
            chk("ready_match", {31'd0, word_ready3}, {31'd0, word_ready});
            if (byte_valid && byte_ready) begin
                if (sb.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL sb_empty: got byte %h expected none", byte_out);
                end else begin
                    e  = sb.pop_front();
                    l2 = (e.ch == 2'd3) && (((nb / 4) % 2) == 1);
                    l3 = (e.ch == 2'd3) && (((nb / 4) % 3) == 2);
                    chk("sb_byte", {22'd0, byte_out, byte_chan}, {22'd0, e.b, e.ch});
                    chk("sb_byte3", {22'd0, byte_out3, byte_chan3}, {22'd0, e.b, e.ch});
                    chk("sb_last", {30'd0, byte_last, byte_last3}, {30'd0, l2, l3});
`ifdef RGGB_UNPACKER_LINE_CNT_EN
                    chk("line_count", {16'd0, line_count}, {16'd0, lc2});
                    chk("line_start", {31'd0, line_start},
                        {31'd0, e.ch == 2'd0 && ((nb / 4) % 2) == 0});
                    if (l2) lc2++;
`endif
                    if (l3) lasts3++;
                end
                nb++;
            end
            if (acc)
                for (int i = 0; i < 4; i++)
                    sb.push_back('{wd[31 - 8 * i -: 8], 2'(i)});
        end
    endtask

    task automatic add(input logic r, input logic wv, input logic [31:0] wd, input logic br,
                       input logic wr, input logic bv, input logic [7:0] b, input logic [1:0] ch,
                       input logic l);
        tab.push_back('{r, wv, wd, br, wr, bv, b, ch, l});
    endtask

    initial begin
        logic a;
        int   words;
        logic [31:0] cur;
        // reset, single word
        add(1,0,0,1,            1,0,8'h00,0,0);
        add(0,1,32'hAABBCCDD,1, 1,0,8'h00,0,0);
        add(0,0,0,1,            1,1,8'hAA,0,0);
        add(0,0,0,1,            1,1,8'hBB,1,0);
        add(0,0,0,1,            1,1,8'hCC,2,0);
        add(0,0,0,1,            1,1,8'hDD,3,0);
        add(0,0,0,1,            1,0,8'h00,0,0);
        // back-to-back words
        add(0,1,32'h01020304,1, 1,0,8'h00,0,0);
        add(0,1,32'h05060708,1, 1,1,8'h01,0,0);
        add(0,1,32'h090A0B0C,1, 0,1,8'h02,1,0);
        add(0,1,32'h090A0B0C,1, 0,1,8'h03,2,0);
        add(0,1,32'h090A0B0C,1, 0,1,8'h04,3,1);
        add(0,1,32'h090A0B0C,1, 1,1,8'h05,0,0);
        add(0,0,0,1,            0,1,8'h06,1,0);
        add(0,0,0,1,            0,1,8'h07,2,0);
        add(0,0,0,1,            0,1,8'h08,3,0);
        add(0,0,0,1,            1,1,8'h09,0,0);
        add(0,0,0,1,            1,1,8'h0A,1,0);
        add(0,0,0,1,            1,1,8'h0B,2,0);
        add(0,0,0,1,            1,1,8'h0C,3,1);
        add(0,0,0,1,            1,0,8'h00,0,0);
        // backpressure with three words offered
        add(0,1,32'h10111213,0, 1,0,8'h00,0,0);
        add(0,1,32'h20212223,0, 1,1,8'h10,0,0);
        add(0,1,32'h30313233,0, 0,1,8'h10,0,0);
        add(0,1,32'h30313233,0, 0,1,8'h10,0,0);
        add(0,1,32'h30313233,1, 0,1,8'h10,0,0);
        add(0,1,32'h30313233,1, 0,1,8'h11,1,0);
        add(0,1,32'h30313233,1, 0,1,8'h12,2,0);
        add(0,1,32'h30313233,1, 0,1,8'h13,3,0);
        add(0,1,32'h30313233,1, 1,1,8'h20,0,0);
        add(0,0,0,1,            0,1,8'h21,1,0);
        add(0,0,0,1,            0,1,8'h22,2,0);
        add(0,0,0,1,            0,1,8'h23,3,1);
        add(0,0,0,1,            1,1,8'h30,0,0);
        add(0,0,0,1,            1,1,8'h31,1,0);
        add(0,0,0,1,            1,1,8'h32,2,0);
        add(0,0,0,1,            1,1,8'h33,3,0);
        add(0,0,0,1,            1,0,8'h00,0,0);
        // reset after G1 consumed with a second word buffered
        add(0,1,32'h11223344,1, 1,0,8'h00,0,0);
        add(0,1,32'h99887766,1, 1,1,8'h11,0,0);
        add(0,0,0,1,            0,1,8'h22,1,0);
        add(1,0,0,0,            0,1,8'h33,2,0);
        add(0,1,32'h55667788,1, 1,0,8'h00,0,0);
        add(0,0,0,1,            1,1,8'h55,0,0);
        add(0,0,0,1,            1,1,8'h66,1,0);
        add(0,0,0,1,            1,1,8'h77,2,0);
        add(0,0,0,1,            1,1,8'h88,3,0);
        add(0,1,32'h0D0E0F00,1, 1,0,8'h00,0,0);
        add(0,0,0,1,            1,1,8'h0D,0,0);
        add(0,0,0,1,            1,1,8'h0E,1,0);
        add(0,0,0,1,            1,1,8'h0F,2,0);
        add(0,0,0,1,            1,1,8'h00,3,1);
        add(0,0,0,1,            1,0,8'h00,0,0);

        step(1, 0, 0, 0, a);
        step(1, 0, 0, 0, a);
        foreach (tab[i]) begin
            step(tab[i].r, tab[i].wv, tab[i].wd, tab[i].br, a);
            chk($sformatf("vec%0d", i),
                {19'd0, word_ready, byte_valid, byte_out, byte_chan, byte_last},
                {19'd0, tab[i].wr, tab[i].bv, tab[i].b, tab[i].ch, tab[i].l});
        end

        // random valid/ready traffic
        step(1, 0, 0, 0, a);
        lasts3 = 0;
        words = 0;
        cur = $urandom;
        for (int c = 0; c < 20000 && words < 1000; c++) begin
            step(0, $urandom_range(0, 9) < 6, cur, $urandom_range(0, 9) < 7, a);
            if (a) begin
                words++;
                cur = $urandom;
            end
        end
        chk("rand_words", words, 1000);
        for (int c = 0; c < 200 && sb.size() != 0; c++)
            step(0, 0, 0, 1, a);
        chk("rand_drain", sb.size(), 0);
        chk("rand_bytes", nb, 4000);
        chk("rand_lasts", lasts3, 333);
        step(0, 0, 0, 1, a);
        chk("rand_idle", {31'd0, byte_valid}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
